// File: rtl/cache_arbiter.sv
// Two-client (icache/dcache) line arbiter onto a single physical-memory port.
// Optional macro ARB_RR_EN: round-robin tie-break; default build is fixed dcache priority.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         i_pmem_read,
    input  logic         i_pmem_write,
    input  logic [31:0]  i_pmem_address,
    input  logic [255:0] i_pmem_wdata,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         i_pend;
    logic         d_pend;
    logic         grant_i;
    logic         grant_d;
    logic         op_read_q;
    logic         op_write_q;
    logic [31:0]  addr_q;
    logic [255:0] wdata_q;

`ifdef ARB_RR_EN
    // Set when dcache received the most recent grant; reset value means icache.
    logic last_d_q;
`endif

    assign i_pend = i_pmem_read | i_pmem_write;
    assign d_pend = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_pend && d_pend) begin
`ifdef ARB_RR_EN
                    grant_i = last_d_q;
                    grant_d = ~last_d_q;
`else
                    grant_d = 1'b1;
`endif
                end else begin
                    grant_i = i_pend;
                    grant_d = d_pend;
                end
                if (grant_i) begin
                    state_nxt = SERVE_I;
                end else if (grant_d) begin
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command is captured on the grant edge; write wins over a simultaneous read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant_i) begin
            op_read_q  <= i_pmem_read & ~i_pmem_write;
            op_write_q <= i_pmem_write;
            addr_q     <= i_pmem_address;
            wdata_q    <= i_pmem_wdata;
        end else if (grant_d) begin
            op_read_q  <= d_pmem_read & ~d_pmem_write;
            op_write_q <= d_pmem_write;
            addr_q     <= d_pmem_address;
            wdata_q    <= d_pmem_wdata;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (grant_i) begin
            last_d_q <= 1'b0;
        end else if (grant_d) begin
            last_d_q <= 1'b1;
        end
    end
`endif

    assign pmem_read    = (state != IDLE) & op_read_q;
    assign pmem_write   = (state != IDLE) & op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client line arbiter sitting directly downstream of the instruction cache and the data cache, multiplexing their 256-bit physical-memory line requests onto the single physical-memory port. Each cache sees a private pmem-style handshake. The arbiter grants one client at a time, latches that client's command, and holds it until memory responds. It then routes the response back to the granted client only.

## Interface
Parameters:
- none (line width fixed at 256 bits, address at 32 bits)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_pmem_read  in  1  icache line-read request, held high until i_pmem_resp
- i_pmem_write  in  1  icache line-write request (tied 0 by icache; still arbitrated)
- i_pmem_address  in  32  icache line address
- i_pmem_wdata  in  256  icache write line
- i_pmem_rdata  out  256  read line to icache
- i_pmem_resp  out  1  one-cycle completion pulse to icache
- d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_rdata, d_pmem_resp: same as the i_ group, for the dcache
- pmem_read  out  1  read command to memory
- pmem_write  out  1  write command to memory
- pmem_address  out  32  latched address
- pmem_wdata  out  256  latched write line
- pmem_rdata  in  256  memory read line
- pmem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - A client is pending when its read or write is high.
  - If only one client is pending, grant it.
  - If both are pending, grant dcache (see Configuration).
  - On the grant edge, latch the address, wdata and op into command registers. Write wins if a client asserts both read and write.
  - Next state is SERVE_I or SERVE_D.
- SERVE_x:
  - pmem_read and pmem_write are driven from the latched op. pmem_address and pmem_wdata are driven from the latched registers, so changes on client inputs are ignored.
  - When pmem_resp is high, x_pmem_resp is driven high in that same cycle (combinational from pmem_resp gated by state), and the next state is IDLE.
  - The non-granted client's resp stays 0 throughout.
- i_pmem_rdata and d_pmem_rdata are both wired to pmem_rdata. Only resp qualifies the data.
- Client protocol: a client deasserts its read/write on the edge after it sees its resp. A request still high in IDLE is treated as a new request.
- pmem_resp in IDLE is ignored: no client resp, no state change.

## Timing
- Reset values: state IDLE; pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0; i_pmem_resp=0, d_pmem_resp=0; last-grant register = icache.
- Grant latency: a request seen in IDLE in cycle 0 drives the pmem command from cycle 1.
- Completion: pmem_resp in cycle k gives x_pmem_resp in cycle k and IDLE in cycle k+1. The earliest next pmem command is cycle k+2.
- Commands never change while in SERVE_x. pmem_read and pmem_write are never both high.
- Reset mid-transaction:
  - The arbiter asynchronously returns to IDLE with all outputs 0.
  - The in-flight memory transaction is abandoned. Memory must tolerate command withdrawal.
  - No resp is generated for the abandoned request.

## Configuration
- ARB_RR_EN defined:
  - On a tie in IDLE, grant the client not granted last.
  - The last-grant register updates on every grant. It resets to icache, so the first tie after reset goes to dcache.
  - Single-client grants also update it.
- ARB_RR_EN undefined:
  - Fixed priority: dcache always wins ties, and the last-grant register is absent.
  - Icache can starve under continuous dcache traffic; this is accepted.

## Test plan
- Single icache read: i_pmem_read=1, addr 0x0000_1040; memory answers after 5 cycles with line 0xA5..A5. Required: pmem_read high from cycle 1 with pmem_address 0x0000_1040; i_pmem_resp pulses one cycle with i_pmem_rdata=0xA5..A5; d_pmem_resp stays 0.
- Dcache write-back: d_pmem_write=1, addr 0x0000_2000, wdata 0x1234..; client changes the address to 0xFFFF_FFFF mid-transaction. Required: pmem_write high, pmem_address held at 0x0000_2000, pmem_wdata unchanged, d_pmem_resp on pmem_resp.
- Simultaneous requests (icache 0x100, dcache 0x200) from reset, macro undefined. Required: dcache is served first, then icache is served after its turnaround with pmem_address=0x100.
- With ARB_RR_EN, both clients requesting continuously for 4 transactions. Required grant order: D, I, D, I.
- Reset asserted while in SERVE_I with pmem_read high. Required: pmem_read=0 and state IDLE immediately; no i_pmem_resp; a fresh request after reset release is served normally.
- Stray pmem_resp in IDLE. Required: no client resp and no state change.
